instr_dispatch_queue: RTL and testbench
=======================================

# instr_dispatch_queue

Parametrised issue stage sitting between instruction fetch and the ROB/RS/LSB back end. Buffers fetched instructions in a circular queue and dispatches at most one per cycle. Dispatch requires a free ROB entry and a free slot in the target station: loads/stores go to the LSB, everything else to the RS. Resolves source operands from RF, ROB, CDB and the previous cycle's rename, and supports backpressure and flush.

## Interface
Parameters:
- XLEN, 32, data/PC width
- ROB_IDX_W, 6, ROB index width
- IQ_DEPTH, 8, queue entries (power of 2, ≥2)
- OPC_W, 6, decoded opcode width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global enable; low = all state and outputs hold
- if_valid / if_instr / if_pc / if_jumped  in  1/32/XLEN/1  fetch push and its payload
- if_ready  out  1  queue not full
- dec_instr  out  32  head instruction to combinational decoder
- dec_opcode / dec_rs1 / dec_rs2 / dec_rd / dec_imm  in  OPC_W/5/5/5/XLEN  decoded head
- dec_is_ls / dec_uses_rd  in  1/1  load-store class; writes rd
- rf_check1 / rf_check2  out  5  RF lookup (= dec_rs1/rs2)
- rf_val1/2, rf_dep1/2, rf_has_dep1/2  in  XLEN/ROB_IDX_W/1  RF lookup result
- rob_check1 / rob_check2  out  ROB_IDX_W  (= rf_dep1/2)
- rob_value_valid1/2, rob_value1/2  in  1/XLEN  ROB lookup result
- cdb_valid / cdb_rob_index / cdb_value  in  1/ROB_IDX_W/XLEN  broadcast bypass
- rob_next_index  in  ROB_IDX_W  index the next allocation receives
- rob_full / rs_full / lsb_full  in  1  target full
- flush  in  1  mispredict flush
- rob_valid, rob_rd, rob_jumped, rob_opcode, rob_pc  out  1/5/1/OPC_W/XLEN  ROB allocation
- rs_valid / lsb_valid  out  1  payload targets RS / LSB
- iss_opcode, iss_val1, iss_dep1, iss_has_dep1, iss_val2, iss_dep2, iss_has_dep2, iss_rob_index, iss_imm, iss_pc  out  shared RS/LSB payload
- rf_valid / rf_regname / rf_regrename  out  1/5/ROB_IDX_W  rename write

## Operation
- Queue: head/tail pointers of clog2(IQ_DEPTH) bits, wrap naturally. Count has clog2(IQ_DEPTH)+1 bits.
- if_ready = (count != IQ_DEPTH), combinational from count only. A push when full is ignored, even if a pop occurs in the same cycle.
- push = if_valid & if_ready & ~flush.
- go = (count != 0) & ~rob_full & ~(dec_is_ls ? lsb_full : rs_full) & ~flush.
- Simultaneous push and go: count unchanged, both pointers advance.
- Operand n resolution, in priority order:
  - rs==0 → val 0, no dep.
  - Pending rename hit (rf_valid & rf_regname==rs) → dep = rf_regrename, val 0.
  - ~rf_has_dep → rf_val.
  - rob_value_valid → rob_value.
  - cdb_valid & cdb_rob_index==rf_dep → cdb_value.
  - Otherwise → has_dep=1, dep=rf_dep, val 0.
  - In every no-dependency case, dep=0.
- On go (registered, next edge):
  - rob_valid=1.
  - rs_valid=~dec_is_ls, lsb_valid=dec_is_ls.
  - Payload loaded; iss_rob_index = rob_rd-side rob_next_index.
  - rf_valid = dec_uses_rd & (dec_rd!=0).
- No go: all valid outputs 0 next edge; payloads hold.
- Flush: count=0, head=tail=0, all valid outputs 0 next edge. Flush beats push and go.

## Timing
- Reset: queue empty, pointers 0, all outputs 0 (if_ready=1 after reset).
- Push at edge N → entry dispatchable in cycle N+1 at the earliest. Minimum fetch-to-issue latency is 2 edges.
- Dispatch throughput is 1/cycle. Valid outputs are single-cycle pulses per instruction.
- Pending-rename forwarding covers the one-cycle gap before the RF records the rename.
- rdy=0 at any time: freeze, including mid-flush. rst overrides rdy.

## Test plan
- Reset, then push 3 ALU ops (rd=1,2,3; no deps) on consecutive cycles → rs_valid pulses at cycles 2,3,4; iss_rob_index follows rob_next_index; rf_regname 1,2,3.
- Back-to-back `add x5` then `add x6,x5,x5` → second issue has has_dep1=has_dep2=1 and dep = first's rob index (pending-rename path).
- Fill 8 entries with rs_full=1 → if_ready=0; a 9th push is dropped. Release rs_full → 8 issues in order with correct PCs.
- Load at head with lsb_full=1, rs_full=0 → stalls; lsb_full→0 → lsb_valid=1, rs_valid=0.
- rf_has_dep1=1, rob_value_valid1=0, cdb_valid with matching index, cdb_value=0xDEADBEEF → iss_val1=0xDEADBEEF, has_dep1=0, dep1=0.
- Queue holds 5 entries, flush concurrent with if_valid → next cycle count=0, no valids, pushed instruction dropped; rd=0 dispatch → rf_valid=0.

Source files
------------

// File: rtl/instr_dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_dispatch_queue_if
// Brief    : Fetch, decode, lookup, bypass and dispatch signals of the issue stage
// Revision : 1.0
// ============================================================================
interface instr_dispatch_queue_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_IDX_W = 6,
    parameter int unsigned OPC_W     = 6
);
    logic                 if_valid;
    logic [31:0]          if_instr;
    logic [XLEN-1:0]      if_pc;
    logic                 if_jumped;
    logic                 if_ready;

    logic [31:0]          dec_instr;
    logic [OPC_W-1:0]     dec_opcode;
    logic [4:0]           dec_rs1;
    logic [4:0]           dec_rs2;
    logic [4:0]           dec_rd;
    logic [XLEN-1:0]      dec_imm;
    logic                 dec_is_ls;
    logic                 dec_uses_rd;

    logic [4:0]           rf_check1;
    logic [4:0]           rf_check2;
    logic [XLEN-1:0]      rf_val1;
    logic [XLEN-1:0]      rf_val2;
    logic [ROB_IDX_W-1:0] rf_dep1;
    logic [ROB_IDX_W-1:0] rf_dep2;
    logic                 rf_has_dep1;
    logic                 rf_has_dep2;

    logic [ROB_IDX_W-1:0] rob_check1;
    logic [ROB_IDX_W-1:0] rob_check2;
    logic                 rob_value_valid1;
    logic                 rob_value_valid2;
    logic [XLEN-1:0]      rob_value1;
    logic [XLEN-1:0]      rob_value2;

    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_index;
    logic [XLEN-1:0]      cdb_value;

    logic [ROB_IDX_W-1:0] rob_next_index;
    logic                 rob_full;
    logic                 rs_full;
    logic                 lsb_full;
    logic                 flush;

    logic                 rob_valid;
    logic [4:0]           rob_rd;
    logic                 rob_jumped;
    logic [OPC_W-1:0]     rob_opcode;
    logic [XLEN-1:0]      rob_pc;

    logic                 rs_valid;
    logic                 lsb_valid;
    logic [OPC_W-1:0]     iss_opcode;
    logic [XLEN-1:0]      iss_val1;
    logic [ROB_IDX_W-1:0] iss_dep1;
    logic                 iss_has_dep1;
    logic [XLEN-1:0]      iss_val2;
    logic [ROB_IDX_W-1:0] iss_dep2;
    logic                 iss_has_dep2;
    logic [ROB_IDX_W-1:0] iss_rob_index;
    logic [XLEN-1:0]      iss_imm;
    logic [XLEN-1:0]      iss_pc;

    logic                 rf_valid;
    logic [4:0]           rf_regname;
    logic [ROB_IDX_W-1:0] rf_regrename;

    modport slave (
        input  if_valid, if_instr, if_pc, if_jumped,
        output if_ready,
        output dec_instr,
        input  dec_opcode, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_is_ls, dec_uses_rd,
        output rf_check1, rf_check2,
        input  rf_val1, rf_val2, rf_dep1, rf_dep2, rf_has_dep1, rf_has_dep2,
        output rob_check1, rob_check2,
        input  rob_value_valid1, rob_value_valid2, rob_value1, rob_value2,
        input  cdb_valid, cdb_rob_index, cdb_value,
        input  rob_next_index, rob_full, rs_full, lsb_full, flush,
        output rob_valid, rob_rd, rob_jumped, rob_opcode, rob_pc,
        output rs_valid, lsb_valid,
        output iss_opcode, iss_val1, iss_dep1, iss_has_dep1, iss_val2, iss_dep2, iss_has_dep2,
        output iss_rob_index, iss_imm, iss_pc,
        output rf_valid, rf_regname, rf_regrename
    );

    modport master (
        output if_valid, if_instr, if_pc, if_jumped,
        input  if_ready,
        input  dec_instr,
        output dec_opcode, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_is_ls, dec_uses_rd,
        input  rf_check1, rf_check2,
        output rf_val1, rf_val2, rf_dep1, rf_dep2, rf_has_dep1, rf_has_dep2,
        input  rob_check1, rob_check2,
        output rob_value_valid1, rob_value_valid2, rob_value1, rob_value2,
        output cdb_valid, cdb_rob_index, cdb_value,
        output rob_next_index, rob_full, rs_full, lsb_full, flush,
        input  rob_valid, rob_rd, rob_jumped, rob_opcode, rob_pc,
        input  rs_valid, lsb_valid,
        input  iss_opcode, iss_val1, iss_dep1, iss_has_dep1, iss_val2, iss_dep2, iss_has_dep2,
        input  iss_rob_index, iss_imm, iss_pc,
        input  rf_valid, rf_regname, rf_regrename
    );
endinterface
`default_nettype wire

// File: rtl/instr_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_dispatch_queue
// Brief    : Circular instruction queue issuing one op per cycle to ROB + RS/LSB
// Revision : 1.0
// ============================================================================
module instr_dispatch_queue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_IDX_W = 6,
    parameter int unsigned IQ_DEPTH  = 8,
    parameter int unsigned OPC_W     = 6
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             rdy,
    instr_dispatch_queue_if.slave bus
);
    localparam int unsigned        c_PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned        c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(IQ_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]      val;
        logic [ROB_IDX_W-1:0] dep;
        logic                 has_dep;
    } operand_t;

    logic [31:0]          r_q_instr [IQ_DEPTH];
    logic [XLEN-1:0]      r_q_pc    [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]  r_q_jumped;
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic                 r_rob_valid;
    logic [4:0]           r_rob_rd;
    logic                 r_rob_jumped;
    logic [OPC_W-1:0]     r_rob_opcode;
    logic [XLEN-1:0]      r_rob_pc;
    logic                 r_rs_valid;
    logic                 r_lsb_valid;
    logic [OPC_W-1:0]     r_iss_opcode;
    operand_t             r_iss_op1;
    operand_t             r_iss_op2;
    logic [ROB_IDX_W-1:0] r_iss_rob_index;
    logic [XLEN-1:0]      r_iss_imm;
    logic [XLEN-1:0]      r_iss_pc;
    logic                 r_rf_valid;
    logic [4:0]           r_rf_regname;
    logic [ROB_IDX_W-1:0] r_rf_regrename;

    logic                 w_empty;
    logic                 w_not_full;
    logic                 w_push;
    logic                 w_target_full;
    logic                 w_go;
    logic [XLEN-1:0]      w_head_pc;
    logic                 w_head_jumped;
    operand_t             w_op1;
    operand_t             w_op2;

    // The rename issued last cycle is not yet visible in the RF, so it wins
    // over every RF/ROB/CDB source for the same architectural register.
    function automatic operand_t f_resolve(
        input logic [4:0]           rs,
        input logic [XLEN-1:0]      rf_val,
        input logic [ROB_IDX_W-1:0] rf_dep,
        input logic                 rf_has_dep,
        input logic                 rob_vv,
        input logic [XLEN-1:0]      rob_val,
        input logic                 pend_valid,
        input logic [4:0]           pend_name,
        input logic [ROB_IDX_W-1:0] pend_idx,
        input logic                 cdb_valid,
        input logic [ROB_IDX_W-1:0] cdb_idx,
        input logic [XLEN-1:0]      cdb_val
    );
        operand_t res;
        res = '0;
        if (rs != 5'd0) begin
            if (pend_valid && (pend_name == rs)) begin
                res.has_dep = 1'b1;
                res.dep     = pend_idx;
            end else if (!rf_has_dep) begin
                res.val = rf_val;
            end else if (rob_vv) begin
                res.val = rob_val;
            end else if (cdb_valid && (cdb_idx == rf_dep)) begin
                res.val = cdb_val;
            end else begin
                res.has_dep = 1'b1;
                res.dep     = rf_dep;
            end
        end
        return res;
    endfunction

    assign w_empty       = (r_count == '0);
    assign w_not_full    = (r_count != c_FULL);
    assign w_push        = bus.if_valid & w_not_full & ~bus.flush;
    assign w_target_full = bus.dec_is_ls ? bus.lsb_full : bus.rs_full;
    assign w_go          = ~w_empty & ~bus.rob_full & ~w_target_full & ~bus.flush;
    assign w_head_pc     = r_q_pc[r_head];
    assign w_head_jumped = r_q_jumped[r_head];

    assign w_op1 = f_resolve(bus.dec_rs1, bus.rf_val1, bus.rf_dep1, bus.rf_has_dep1,
                             bus.rob_value_valid1, bus.rob_value1,
                             r_rf_valid, r_rf_regname, r_rf_regrename,
                             bus.cdb_valid, bus.cdb_rob_index, bus.cdb_value);
    assign w_op2 = f_resolve(bus.dec_rs2, bus.rf_val2, bus.rf_dep2, bus.rf_has_dep2,
                             bus.rob_value_valid2, bus.rob_value2,
                             r_rf_valid, r_rf_regname, r_rf_regrename,
                             bus.cdb_valid, bus.cdb_rob_index, bus.cdb_value);

    assign bus.if_ready   = w_not_full;
    assign bus.dec_instr  = w_empty ? 32'd0 : r_q_instr[r_head];
    assign bus.rf_check1  = bus.dec_rs1;
    assign bus.rf_check2  = bus.dec_rs2;
    assign bus.rob_check1 = bus.rf_dep1;
    assign bus.rob_check2 = bus.rf_dep2;

    // Queue storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!rst && rdy && w_push) begin
            r_q_instr[r_tail]  <= bus.if_instr;
            r_q_pc[r_tail]     <= bus.if_pc;
            r_q_jumped[r_tail] <= bus.if_jumped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (bus.flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_go)   r_head <= r_head + 1'b1;
                if (w_push && !w_go)      r_count <= r_count + 1'b1;
                else if (!w_push && w_go) r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rob_valid     <= 1'b0;
            r_rob_rd        <= '0;
            r_rob_jumped    <= 1'b0;
            r_rob_opcode    <= '0;
            r_rob_pc        <= '0;
            r_rs_valid      <= 1'b0;
            r_lsb_valid     <= 1'b0;
            r_iss_opcode    <= '0;
            r_iss_op1       <= '0;
            r_iss_op2       <= '0;
            r_iss_rob_index <= '0;
            r_iss_imm       <= '0;
            r_iss_pc        <= '0;
            r_rf_valid      <= 1'b0;
            r_rf_regname    <= '0;
            r_rf_regrename  <= '0;
        end else if (rdy) begin
            r_rob_valid <= w_go;
            r_rs_valid  <= w_go & ~bus.dec_is_ls;
            r_lsb_valid <= w_go & bus.dec_is_ls;
            r_rf_valid  <= w_go & bus.dec_uses_rd & (bus.dec_rd != 5'd0);
            if (w_go) begin
                r_rob_rd        <= bus.dec_rd;
                r_rob_jumped    <= w_head_jumped;
                r_rob_opcode    <= bus.dec_opcode;
                r_rob_pc        <= w_head_pc;
                r_iss_opcode    <= bus.dec_opcode;
                r_iss_op1       <= w_op1;
                r_iss_op2       <= w_op2;
                r_iss_rob_index <= bus.rob_next_index;
                r_iss_imm       <= bus.dec_imm;
                r_iss_pc        <= w_head_pc;
                r_rf_regname    <= bus.dec_rd;
                r_rf_regrename  <= bus.rob_next_index;
            end
        end
    end

    assign bus.rob_valid     = r_rob_valid;
    assign bus.rob_rd        = r_rob_rd;
    assign bus.rob_jumped    = r_rob_jumped;
    assign bus.rob_opcode    = r_rob_opcode;
    assign bus.rob_pc        = r_rob_pc;
    assign bus.rs_valid      = r_rs_valid;
    assign bus.lsb_valid     = r_lsb_valid;
    assign bus.iss_opcode    = r_iss_opcode;
    assign bus.iss_val1      = r_iss_op1.val;
    assign bus.iss_dep1      = r_iss_op1.dep;
    assign bus.iss_has_dep1  = r_iss_op1.has_dep;
    assign bus.iss_val2      = r_iss_op2.val;
    assign bus.iss_dep2      = r_iss_op2.dep;
    assign bus.iss_has_dep2  = r_iss_op2.has_dep;
    assign bus.iss_rob_index = r_iss_rob_index;
    assign bus.iss_imm       = r_iss_imm;
    assign bus.iss_pc        = r_iss_pc;
    assign bus.rf_valid      = r_rf_valid;
    assign bus.rf_regname    = r_rf_regname;
    assign bus.rf_regrename  = r_rf_regrename;
endmodule
`default_nettype wire

// File: tb/tb_instr_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_dispatch_queue
// Brief    : Directed + randomized bench with a queue-level reference model
// Revision : 1.0
// ============================================================================
module tb_instr_dispatch_queue;
    localparam int XLEN  = 32;
    localparam int RW    = 6;
    localparam int DEPTH = 8;
    localparam int OPC_W = 6;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    instr_dispatch_queue_if #(.XLEN(XLEN), .ROB_IDX_W(RW), .OPC_W(OPC_W)) bus ();

    instr_dispatch_queue #(.XLEN(XLEN), .ROB_IDX_W(RW), .IQ_DEPTH(DEPTH), .OPC_W(OPC_W)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    // Environment decoder: opc[5:0] ls[6] rd[11:7] uses_rd[12] rs1[19:15] rs2[24:20] imm7[31:25]
    assign bus.dec_opcode  = bus.dec_instr[5:0];
    assign bus.dec_is_ls   = bus.dec_instr[6];
    assign bus.dec_rd      = bus.dec_instr[11:7];
    assign bus.dec_uses_rd = bus.dec_instr[12];
    assign bus.dec_rs1     = bus.dec_instr[19:15];
    assign bus.dec_rs2     = bus.dec_instr[24:20];
    assign bus.dec_imm     = {{25{bus.dec_instr[31]}}, bus.dec_instr[31:25]};

    // Register file and ROB lookup tables
    logic [31:0]   t_rf_val  [32];
    logic [RW-1:0] t_rf_dep  [32];
    logic          t_rf_hd   [32];
    logic          t_rob_vv  [64];
    logic [31:0]   t_rob_val [64];

    assign bus.rf_val1          = t_rf_val[bus.rf_check1];
    assign bus.rf_val2          = t_rf_val[bus.rf_check2];
    assign bus.rf_dep1          = t_rf_dep[bus.rf_check1];
    assign bus.rf_dep2          = t_rf_dep[bus.rf_check2];
    assign bus.rf_has_dep1      = t_rf_hd[bus.rf_check1];
    assign bus.rf_has_dep2      = t_rf_hd[bus.rf_check2];
    assign bus.rob_value_valid1 = t_rob_vv[bus.rob_check1];
    assign bus.rob_value_valid2 = t_rob_vv[bus.rob_check2];
    assign bus.rob_value1       = t_rob_val[bus.rob_check1];
    assign bus.rob_value2       = t_rob_val[bus.rob_check2];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        j;
    } ent_t;

    ent_t        mq[$];
    logic        e_rob_valid, e_rs_valid, e_lsb_valid, e_rf_valid, e_rob_jumped, e_hd1, e_hd2;
    logic [4:0]  e_rob_rd, e_regname;
    logic [5:0]  e_opc, e_dep1, e_dep2, e_rob_index, e_regrename;
    logic [31:0] e_rob_pc, e_val1, e_val2, e_imm, e_iss_pc;

    function automatic logic [31:0] mk(input logic [5:0] opc, input logic ls, input logic [4:0] rd,
                                       input logic urd, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [6:0] imm);
        return {imm, rs2, rs1, 2'b00, urd, rd, ls, opc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_exp();
        {e_rob_valid, e_rs_valid, e_lsb_valid, e_rf_valid, e_rob_jumped, e_hd1, e_hd2} = '0;
        e_rob_rd = '0; e_regname = '0; e_opc = '0; e_dep1 = '0; e_dep2 = '0;
        e_rob_index = '0; e_regrename = '0; e_rob_pc = '0; e_val1 = '0; e_val2 = '0;
        e_imm = '0; e_iss_pc = '0;
    endtask

    task automatic resolve(input logic [4:0] rs, output logic [31:0] v, output logic [5:0] d, output logic h);
        logic [5:0] pd;
        v = '0; d = '0; h = 1'b0;
        pd = t_rf_dep[rs];
        if (rs == 5'd0) return;
        if (e_rf_valid && e_regname == rs) begin h = 1'b1; d = e_regrename; return; end
        if (!t_rf_hd[rs]) begin v = t_rf_val[rs]; return; end
        if (t_rob_vv[pd]) begin v = t_rob_val[pd]; return; end
        if (bus.cdb_valid && bus.cdb_rob_index == pd) begin v = bus.cdb_value; return; end
        h = 1'b1; d = pd;
    endtask

    // Predicts the architectural effect of the coming clock edge.
    task automatic model_edge();
        logic [31:0] ins, v1, v2;
        logic [5:0]  d1, d2;
        logic        h1, h2, go, push, ls, urd;
        logic [4:0]  rd;
        ent_t        e;
        if (rst) begin mq.delete(); clear_exp(); return; end
        if (!rdy) return;
        push = bus.if_valid && (mq.size() < DEPTH) && !bus.flush;
        go = 1'b0; ins = '0; e = '{default: '0};
        if (mq.size() > 0 && !bus.flush) begin
            e   = mq[0];
            ins = e.instr;
            go  = !bus.rob_full && !(ins[6] ? bus.lsb_full : bus.rs_full);
        end
        ls = ins[6]; rd = ins[11:7]; urd = ins[12];
        if (go) begin
            resolve(ins[19:15], v1, d1, h1);
            resolve(ins[24:20], v2, d2, h2);
            e_rob_rd = rd; e_rob_jumped = e.j; e_opc = ins[5:0]; e_rob_pc = e.pc;
            e_val1 = v1; e_dep1 = d1; e_hd1 = h1; e_val2 = v2; e_dep2 = d2; e_hd2 = h2;
            e_rob_index = bus.rob_next_index; e_imm = {{25{ins[31]}}, ins[31:25]};
            e_iss_pc = e.pc; e_regname = rd; e_regrename = bus.rob_next_index;
        end
        e_rob_valid = go;
        e_rs_valid  = go && !ls;
        e_lsb_valid = go && ls;
        e_rf_valid  = go && urd && (rd != 5'd0);
        if (bus.flush) mq.delete();
        else begin
            if (go) void'(mq.pop_front());
            if (push) mq.push_back('{bus.if_instr, bus.if_pc, bus.if_jumped});
        end
    endtask

    task automatic check_all();
        logic [31:0] ed;
        ed = '0;
        if (mq.size() != 0) ed = mq[0].instr;
        chk("if_ready", 64'(bus.if_ready), 64'(mq.size() != DEPTH));
        chk("dec_instr", 64'(bus.dec_instr), 64'(ed));
        chk("rob_valid", 64'(bus.rob_valid), 64'(e_rob_valid));
        chk("rs_valid", 64'(bus.rs_valid), 64'(e_rs_valid));
        chk("lsb_valid", 64'(bus.lsb_valid), 64'(e_lsb_valid));
        chk("rf_valid", 64'(bus.rf_valid), 64'(e_rf_valid));
        chk("rob_rd", 64'(bus.rob_rd), 64'(e_rob_rd));
        chk("rob_jumped", 64'(bus.rob_jumped), 64'(e_rob_jumped));
        chk("rob_opcode", 64'(bus.rob_opcode), 64'(e_opc));
        chk("rob_pc", 64'(bus.rob_pc), 64'(e_rob_pc));
        chk("iss_opcode", 64'(bus.iss_opcode), 64'(e_opc));
        chk("iss_val1", 64'(bus.iss_val1), 64'(e_val1));
        chk("iss_dep1", 64'(bus.iss_dep1), 64'(e_dep1));
        chk("iss_has_dep1", 64'(bus.iss_has_dep1), 64'(e_hd1));
        chk("iss_val2", 64'(bus.iss_val2), 64'(e_val2));
        chk("iss_dep2", 64'(bus.iss_dep2), 64'(e_dep2));
        chk("iss_has_dep2", 64'(bus.iss_has_dep2), 64'(e_hd2));
        chk("iss_rob_index", 64'(bus.iss_rob_index), 64'(e_rob_index));
        chk("iss_imm", 64'(bus.iss_imm), 64'(e_imm));
        chk("iss_pc", 64'(bus.iss_pc), 64'(e_iss_pc));
        chk("rf_regname", 64'(bus.rf_regname), 64'(e_regname));
        chk("rf_regrename", 64'(bus.rf_regrename), 64'(e_regrename));
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1;
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.if_jumped = 1'b0;
        bus.cdb_valid = 1'b0; bus.cdb_rob_index = '0; bus.cdb_value = '0;
        bus.rob_next_index = '0; bus.rob_full = 1'b0; bus.rs_full = 1'b0;
        bus.lsb_full = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic randomize_tables();
        for (int r = 0; r < 32; r++) begin
            t_rf_val[r] = $urandom;
            t_rf_dep[r] = 6'($urandom_range(0, 7));
            t_rf_hd[r]  = 1'($urandom);
        end
        for (int r = 0; r < 64; r++) begin
            t_rob_vv[r]  = ($urandom_range(0, 2) == 0);
            t_rob_val[r] = $urandom;
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin t_rf_val[r] = '0; t_rf_dep[r] = '0; t_rf_hd[r] = 1'b0; end
        for (int r = 0; r < 64; r++) begin t_rob_vv[r] = 1'b0; t_rob_val[r] = '0; end
        clear_exp();
        idle();

        // Reset state
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_if_ready", 64'(bus.if_ready), 64'd1);
        chk("rst_rob_valid", 64'(bus.rob_valid), 64'd0);

        // Three ALU ops pushed back to back issue on edges 2,3,4
        for (int i = 0; i < 5; i++) begin
            bus.if_valid = (i < 3);
            bus.if_instr = mk(6'h01, 1'b0, 5'(i + 1), 1'b1, 5'd0, 5'd0, 7'd0);
            bus.if_pc = 32'h1000 + 32'(4 * i);
            bus.rob_next_index = 6'(19 + i);
            step();
            chk("t1_rs_valid", 64'(bus.rs_valid), 64'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) begin
                chk("t1_regname", 64'(bus.rf_regname), 64'(i));
                chk("t1_rob_index", 64'(bus.iss_rob_index), 64'(19 + i));
            end
        end

        // Dependent pair resolved through the pending-rename path
        t_rf_val[5] = 32'h55;
        for (int i = 0; i < 3; i++) begin
            bus.if_valid = (i < 2);
            bus.if_instr = (i == 0) ? mk(6'h02, 1'b0, 5'd5, 1'b1, 5'd0, 5'd0, 7'd0)
                                    : mk(6'h02, 1'b0, 5'd6, 1'b1, 5'd5, 5'd5, 7'd0);
            bus.rob_next_index = 6'(29 + i);
            step();
        end
        chk("t2_has_dep1", 64'(bus.iss_has_dep1), 64'd1);
        chk("t2_has_dep2", 64'(bus.iss_has_dep2), 64'd1);
        chk("t2_dep1", 64'(bus.iss_dep1), 64'd30);
        chk("t2_dep2", 64'(bus.iss_dep2), 64'd30);
        chk("t2_val1", 64'(bus.iss_val1), 64'd0);

        // Fill under RS backpressure; 9th push is dropped; drain in order
        bus.rs_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.if_valid = 1'b1;
            bus.if_instr = mk(6'h03, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 7'(i));
            bus.if_pc = 32'h100 + 32'(4 * i);
            step();
            if (i >= 7) chk("t3_full", 64'(bus.if_ready), 64'd0);
        end
        bus.if_valid = 1'b0; bus.rs_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_rs_valid", 64'(bus.rs_valid), 64'd1);
            chk("t3_pc", 64'(bus.iss_pc), 64'(32'h100 + 32'(4 * i)));
        end
        step();
        chk("t3_drained", 64'(bus.rs_valid), 64'd0);

        // Load stalls on a full LSB while the RS has room
        bus.lsb_full = 1'b1;
        bus.if_valid = 1'b1; bus.if_instr = mk(6'h04, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 7'd0);
        step(); bus.if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall", 64'(bus.lsb_valid), 64'd0);
        end
        bus.lsb_full = 1'b0;
        step();
        chk("t4_lsb_valid", 64'(bus.lsb_valid), 64'd1);
        chk("t4_rs_valid", 64'(bus.rs_valid), 64'd0);

        // CDB bypass of an RF dependency not yet valid in the ROB
        t_rf_hd[7] = 1'b1; t_rf_dep[7] = 6'd9; t_rob_vv[9] = 1'b0;
        bus.cdb_valid = 1'b1; bus.cdb_rob_index = 6'd9; bus.cdb_value = 32'hDEADBEEF;
        bus.if_valid = 1'b1; bus.if_instr = mk(6'h05, 1'b0, 5'd8, 1'b1, 5'd7, 5'd0, 7'd0);
        step(); bus.if_valid = 1'b0;
        step();
        chk("t5_val1", 64'(bus.iss_val1), 64'hDEADBEEF);
        chk("t5_has_dep1", 64'(bus.iss_has_dep1), 64'd0);
        chk("t5_dep1", 64'(bus.iss_dep1), 64'd0);
        bus.cdb_valid = 1'b0;

        // Flush with a concurrent push empties the queue; rd=0 gives no rename
        bus.rs_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.if_valid = 1'b1; bus.if_instr = mk(6'h06, 1'b0, 5'd3, 1'b1, 5'd0, 5'd0, 7'(i));
            step();
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.if_valid = 1'b0; bus.rs_full = 1'b0;
        chk("t6_if_ready", 64'(bus.if_ready), 64'd1);
        chk("t6_dec_instr", 64'(bus.dec_instr), 64'd0);
        step();
        chk("t6_no_issue", 64'(bus.rob_valid), 64'd0);
        bus.if_valid = 1'b1; bus.if_instr = mk(6'h07, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 7'd0);
        step(); bus.if_valid = 1'b0;
        step();
        chk("t6_rs_valid", 64'(bus.rs_valid), 64'd1);
        chk("t6_rf_valid", 64'(bus.rf_valid), 64'd0);

        // Randomized traffic with freeze, flush, reset and backpressure
        randomize_tables();
        for (int c = 0; c < 3000; c++) begin
            int stall_pct;
            stall_pct = ((c / 400) % 2 == 0) ? 15 : 45;
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            bus.flush = ($urandom_range(0, 29) == 0);
            bus.if_valid = ($urandom_range(0, 9) < 7);
            bus.if_instr = mk(6'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 7'($urandom));
            bus.if_pc = $urandom;
            bus.if_jumped = 1'($urandom);
            bus.cdb_valid = 1'($urandom);
            bus.cdb_rob_index = 6'($urandom_range(0, 7));
            bus.cdb_value = $urandom;
            bus.rob_next_index = 6'($urandom);
            bus.rob_full = ($urandom_range(0, 99) < stall_pct);
            bus.rs_full  = ($urandom_range(0, 99) < stall_pct);
            bus.lsb_full = ($urandom_range(0, 99) < stall_pct);
            if (c % 4 == 0) randomize_tables();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
